// File: rtl/mul_word_x_wide.sv
// Purpose : multi-cycle WORD_W x B_W multiplier, LANES lane products per iteration with a carry word.
// Latency : done pulses ITERS cycles after an accepted start (ITERS = B_W/(WORD_W*LANES)).
// Backpres: start is sampled only in IDLE; start while busy is ignored, never queued.
//
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous active-low reset
//   start  - request, accepted only when idle (including the done cycle)
//   a, b   - operands, captured on the accepting edge
//   acc_in - addend captured with a/b (only when MUL_ACC_EN is defined)
//   busy   - high while iterating
//   out    - a*b (+acc_in), valid from the done cycle until the next accepted start
//   done   - one-cycle completion pulse
//
// Optional feature macro: MUL_ACC_EN (multiply-accumulate, out = a*b + acc_in).
module mul_word_x_wide #(
  parameter int WORD_W = 16,
  parameter int B_W    = 256,
  parameter int LANES  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [WORD_W-1:0]       a,
  input  logic [B_W-1:0]          b,
`ifdef MUL_ACC_EN
  input  logic [B_W-1:0]          acc_in,
`endif
  output logic                    busy,
  output logic [B_W+WORD_W-1:0]   out,
  output logic                    done
);

  localparam int GW    = WORD_W * LANES;        // bits of b consumed per iteration
  localparam int ITERS = B_W / GW;
  localparam int CNT_W = $clog2(ITERS + 1);
  localparam int SW    = WORD_W * (LANES + 1);  // per-step sum width, never overflows
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITERS - 1);

  generate
    if ((B_W % GW) != 0 || B_W < GW) begin : g_bad_width
      $error("mul_word_x_wide: B_W must be a nonzero multiple of WORD_W*LANES");
    end
  endgenerate

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state, state_nxt;
  logic                accept, step, last;
  logic [CNT_W-1:0]    count;
  logic [WORD_W-1:0]   carry;
  logic [WORD_W-1:0]   a_q;
  logic [B_W-1:0]      b_q;
`ifdef MUL_ACC_EN
  logic [B_W-1:0]      acc_q;
`endif
  logic [2*WORD_W-1:0] prod [LANES];
  logic [SW-1:0]       sum;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and step controls
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    step      = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        last = (count == LAST_CNT);
        if (last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One group step: LANES word products of a_q against the low group of b_q,
  // each shifted into its lane position, plus the carry word from the previous group.
  always_comb begin
    sum = SW'(carry);
    for (int i = 0; i < LANES; i++) begin
      prod[i] = a_q * b_q[WORD_W*i +: WORD_W];
      sum     = sum + (SW'(prod[i]) << (WORD_W * i));
    end
`ifdef MUL_ACC_EN
    sum = sum + SW'(acc_q[GW-1:0]);
`endif
  end

  // Datapath and handshake registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      carry <= '0;
      a_q   <= '0;
      b_q   <= '0;
`ifdef MUL_ACC_EN
      acc_q <= '0;
`endif
      out   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        a_q   <= a;
        b_q   <= b;
`ifdef MUL_ACC_EN
        acc_q <= acc_in;
`endif
        carry <= '0;
        count <= '0;
        out   <= '0;
        busy  <= 1'b1;
      end else if (step) begin
        // Constant-index slice writes keep the group select a plain decoder.
        for (int g = 0; g < ITERS; g++) begin
          if (count == CNT_W'(g)) out[g*GW +: GW] <= sum[GW-1:0];
        end
        carry <= sum[SW-1 -: WORD_W];
        b_q   <= b_q >> GW;
`ifdef MUL_ACC_EN
        acc_q <= acc_q >> GW;
`endif
        count <= count + CNT_W'(1);
        if (last) begin
          out[B_W +: WORD_W] <= sum[SW-1 -: WORD_W];
          busy               <= 1'b0;
          done               <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mul_word_x_wide.sv
// Purpose : self-checking bench for mul_word_x_wide (default build and two narrow variants).
// Latency : checks done arrives ITERS edges after acceptance, busy window and single pulse.
// Backpres: exercises start held high during RUN and relaunch in the done cycle.
module tb_mul_word_x_wide;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [15:0]  a = '0;
  logic [255:0] b = '0;
  logic [255:0] acc = '0;
  logic         busy, done;
  logic [271:0] out;

  // Narrow variants: W=8, B=64 with LANES=2 (ITERS=4) and LANES=8 (ITERS=1)
  logic         start_s = 1'b0;
  logic [7:0]   a_s = '0;
  logic [63:0]  b_s = '0;
  logic [63:0]  acc_s = '0;
  logic         busy1, done1, busy2, done2;
  logic [71:0]  out1, out2;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  mul_word_x_wide u0 (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
`ifdef MUL_ACC_EN
    .acc_in(acc),
`endif
    .busy(busy), .out(out), .done(done));

  mul_word_x_wide #(.WORD_W(8), .B_W(64), .LANES(2)) u1 (
    .clk(clk), .reset(reset), .start(start_s), .a(a_s), .b(b_s),
`ifdef MUL_ACC_EN
    .acc_in(acc_s),
`endif
    .busy(busy1), .out(out1), .done(done1));

  mul_word_x_wide #(.WORD_W(8), .B_W(64), .LANES(8)) u2 (
    .clk(clk), .reset(reset), .start(start_s), .a(a_s), .b(b_s),
`ifdef MUL_ACC_EN
    .acc_in(acc_s),
`endif
    .busy(busy2), .out(out2), .done(done2));

  task automatic chk(input logic [271:0] obs, input logic [271:0] exp_v, input string tag);
    compared++;
    assert (obs === exp_v)
    else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Reference: exact integer product (plus addend) in the full output width.
  function automatic logic [271:0] ref_wide(input logic [15:0] ta, input logic [255:0] tb_,
                                            input logic [255:0] tacc);
    logic [271:0] r;
    r = 272'(ta) * 272'(tb_);
`ifdef MUL_ACC_EN
    r = r + 272'(tacc);
`endif
    return r;
  endfunction

  function automatic logic [71:0] ref_narrow(input logic [7:0] ta, input logic [63:0] tb_,
                                             input logic [63:0] tacc);
    logic [71:0] r;
    r = 72'(ta) * 72'(tb_);
`ifdef MUL_ACC_EN
    r = r + 72'(tacc);
`endif
    return r;
  endfunction

  // Waits for done on u0; returns edges after acceptance and cycles with busy seen.
  task automatic wait_done(output int n, output int bcnt);
    n    = 0;
    bcnt = busy ? 1 : 0;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (!done && busy) bcnt++;
    end
  endtask

  task automatic op0(input logic [15:0] ta, input logic [255:0] tb_, input logic [255:0] tacc,
                     input string tag);
    logic [271:0] exp_v;
    int n, bcnt;
    exp_v = ref_wide(ta, tb_, tacc);
    a = ta; b = tb_; acc = tacc; start = 1'b1;
    @(posedge clk); #1;
    // Operands are scrambled right after capture; the result must not change.
    start = 1'b0; a = 16'($urandom); b = rnd256(); acc = rnd256();
    wait_done(n, bcnt);
    chk(272'(n), 272'(4), {tag, "_latency"});
    chk(272'(bcnt), 272'(4), {tag, "_busy_cycles"});
    chk(272'(busy), 272'(0), {tag, "_busy_in_done"});
    chk(out, exp_v, {tag, "_out"});
    @(posedge clk); #1;
    chk(272'(done), 272'(0), {tag, "_done_one_pulse"});
  endtask

  task automatic op_sweep(input logic [7:0] ta, input logic [63:0] tb_, input logic [63:0] tacc,
                          input string tag);
    logic [71:0] exp_v, o1, o2;
    int lat1, lat2;
    exp_v = ref_narrow(ta, tb_, tacc);
    lat1 = -1; lat2 = -1; o1 = '0; o2 = '0;
    a_s = ta; b_s = tb_; acc_s = tacc; start_s = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0; a_s = 8'($urandom); b_s = {$urandom, $urandom}; acc_s = {$urandom, $urandom};
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk); #1;
      if (done1 && lat1 < 0) begin lat1 = n; o1 = out1; end
      if (done2 && lat2 < 0) begin lat2 = n; o2 = out2; end
    end
    chk(272'(lat1), 272'(4), {tag, "_l2_latency"});
    chk(272'(lat2), 272'(1), {tag, "_l8_latency"});
    chk(272'(o1), 272'(exp_v), {tag, "_l2_out"});
    chk(272'(o2), 272'(exp_v), {tag, "_l8_out"});
  endtask

  initial begin
    int n, bcnt, dcnt;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk(out, 272'(0), "rst_out");
    chk(272'(busy), 272'(0), "rst_busy");
    chk(272'(done), 272'(0), "rst_done");
    chk(272'({out1, out2}), 272'(0), "rst_narrow_out");
    reset = 1'b1;
    @(posedge clk); #1;
    chk(272'(busy), 272'(0), "idle_busy");

    // Full range
    op0(16'hFFFF, {256{1'b1}}, 256'd0, "full");
    chk(272'(out[271:256]), 272'(16'hFFFE), "full_top_word");
    chk(272'(out[255:16]), 272'({240{1'b1}}), "full_mid");
    chk(272'(out[15:0]), 272'(16'h0001), "full_low_word");

    // Carry into the top word and zero operand
    op0(16'h0002, 256'd1 << 255, 256'd0, "carry_top");
    chk(272'(out[271:256]), 272'(1), "carry_top_word");
    op0(16'h0000, rnd256(), 256'd0, "a_zero");

    // start held high during RUN is ignored; held into the done cycle relaunches
    a = 16'd3; b = 256'd5; acc = '0; start = 1'b1;
    @(posedge clk); #1;
    a = 16'd7; b = 256'd9;
    wait_done(n, bcnt);
    chk(272'(n), 272'(4), "hold_latency");
    chk(out, 272'(15), "hold_out_first");
    @(posedge clk); #1;
    start = 1'b0;
    chk(272'(done), 272'(0), "hold_single_pulse");
    chk(272'(busy), 272'(1), "hold_relaunch_busy");
    wait_done(n, bcnt);
    chk(272'(n), 272'(4), "relaunch_latency");
    chk(out, 272'(63), "relaunch_out");
    @(posedge clk); #1;

    // Reset mid-operation at edge E2
    a = 16'($urandom); b = rnd256(); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk);
    reset = 1'b0;
    #1;
    chk(out, 272'(0), "midrst_out");
    chk(272'(busy), 272'(0), "midrst_busy");
    chk(272'(done), 272'(0), "midrst_done");
    dcnt = 0;
    repeat (5) begin
      @(posedge clk); #1;
      dcnt += done ? 1 : 0;
    end
    chk(272'(dcnt), 272'(0), "midrst_no_done");
    reset = 1'b1;
    @(posedge clk); #1;
    op0(16'h0001, 256'h1234, 256'd0, "post_rst");

    // Random operands on the default build
    for (int i = 0; i < 6; i++) begin
      op0(16'($urandom), rnd256(), rnd256(), "rand");
    end

    // Narrow variants
    op_sweep(8'hFF, {64{1'b1}}, 64'd0, "sw_full");
    for (int i = 0; i < 5; i++) begin
      op_sweep(8'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, "sw_rand");
    end

`ifdef MUL_ACC_EN
    // Multiply-accumulate at full range
    op0(16'hFFFF, {256{1'b1}}, {256{1'b1}}, "mac_full");
    chk(272'(out[271:256]), 272'(16'hFFFF), "mac_top_word");
    chk(272'(out[255:16]), 272'({240{1'b1}}), "mac_mid");
    chk(272'(out[15:0]), 272'(16'h0000), "mac_low_word");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
